power_channel_arbiter: RTL and testbench
========================================

# power_channel_arbiter

Round-robin scheduler that shares one fixed-latency complex-to-power unit (magnitude-squared, `DW+1`-bit result) among `NCH` complex sample streams. It sits between the per-channel downconverter outputs and the detection logic. Each channel gets a one-deep holding register. The block issues at most one sample per cycle to the shared unit and tags every issue with its channel number. It re-associates each returned power value with its channel through a delay line matched to the unit latency.

## Interface
Parameters:
- `DW`, 16, signed sample width per component
- `NCH`, 4, number of channels (2..16)
- `PU_LAT`, 2, fixed cycles from `pu_valid_o` high to the matching `pu_power_i` being valid (≥1)
- `CW`, `$clog2(NCH)`, channel-tag width (derived)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `data_i_re`  in  `NCH*DW`  packed signed real parts; channel k at bits `[k*DW +: DW]`
- `data_i_im`  in  `NCH*DW`  packed signed imaginary parts, same packing
- `valid_i`  in  `NCH`  per-channel sample strobe, one sample per high cycle
- `chan_en_i`  in  `NCH`  per-channel enable; `valid_i[k]` is ignored while `chan_en_i[k]`=0
- `ovf_clr_i`  in  1  clears all sticky overflow flags
- `pu_re_o`, `pu_im_o`  out  `DW`  sample issued to the shared unit
- `pu_valid_o`  out  1  issue strobe to the shared unit
- `pu_power_i`  in  `DW+1`  result from the shared unit; sampled only when the tag delay line says so
- `power_o`  out  `DW+1`  power result
- `chan_o`  out  `CW`  channel of `power_o`
- `valid_o`  out  1  result strobe, one cycle per result
- `ovf_o`  out  `NCH`  sticky per-channel overflow (sample dropped)

## Operation
- **Holding stage, per channel k.** Registers `hold_re[k]` and `hold_im[k]` plus a `pend[k]` bit.
  - On `valid_i[k] & chan_en_i[k]`:
    - If `pend[k]`=0, or channel k is granted this cycle: load the hold registers and set `pend[k]`.
    - Otherwise: drop the new sample, keep the held sample, and set `ovf_o[k]`.
  - On grant of k with no new arrival: clear `pend[k]`.
  - Deasserting `chan_en_i[k]` does not flush a pending sample; it is still served.
- **Arbiter.** Combinational round-robin over `pend`.
  - A register `last` holds the last granted channel (reset: `NCH-1`, so channel 0 has first priority).
  - The grant goes to the first pending channel in order `last+1, last+2, …`, wrapping modulo `NCH`.
  - At most one grant per cycle. `last` updates only on a grant.
- **Issue register.** On a grant, `pu_re_o`/`pu_im_o` take the granted hold contents and `pu_valid_o` is 1 for the next cycle. With no grant, `pu_valid_o` is 0 and the data registers hold their values.
- **Tag delay line.** `PU_LAT` stages of {valid, channel}, shifted every cycle. Stage 0 loads {`pu_valid_o`, channel of the current issue}.
  - When the last stage is valid, the block registers `power_o <= pu_power_i`, sets `chan_o` to that stage's channel, and pulses `valid_o`.
  - Any valid signal driven by the shared unit is not used.
- **Overflow.** Flags are sticky. `ovf_clr_i` clears all flags; a new overflow in the same cycle as `ovf_clr_i` wins, so that flag stays set.
- **Width.** Data passes through unchanged; the block does no arithmetic on sample or power values.

## Timing
- **Reset values.** `pu_re_o`, `pu_im_o`, `pu_valid_o`, `power_o`, `chan_o`, `valid_o`, `ovf_o`, all `pend`, and every tag-stage valid are 0. `last` = `NCH-1`.
- **Uncontended latency**, with a sample on `valid_i` in cycle 0:
  - `pend` is set in cycle 1 and the grant happens in cycle 1.
  - `pu_valid_o` is high in cycle 2.
  - The unit result is present in cycle `2+PU_LAT`.
  - `valid_o` is high in cycle `3+PU_LAT` (cycle 5 at the default).
- **Throughput.** One result per cycle aggregate. A channel whose `valid_i` pulses are at least `NCH` cycles apart never overflows, whatever the other channels do.
- **Ordering.** Results leave in issue order. Per channel, results are in sample order.
- **Reset mid-operation.** All pending samples and in-flight tags are discarded. Unit results that return after reset never produce `valid_o`.
- **Enable in the same cycle as a sample.** If `chan_en_i[k]` falls in the same cycle as `valid_i[k]`, the sample is ignored.

## Test plan
- **Single sample.** Reset, then channel 2 gets re=3, im=-4 in cycle 0, with a bench model of the unit returning 25 after `PU_LAT`=2. Required: `pu_valid_o` high in cycle 2 with re=3, im=-4; `valid_o` high in cycle 5 with `power_o`=25 and `chan_o`=2; `ovf_o`=0.
- **Fairness.** All 4 channels pulse `valid_i` together every 4 cycles for 40 cycles. Required: issue order 0,1,2,3 repeating; 40 results with correct channel tags; `ovf_o` stays 0.
- **Overflow.** Channel 1 gets samples in cycles 0 and 1 while channels 0, 2 and 3 are continuously pending. Required: the first sample is issued; the second is either held or dropped per the grant timing; `ovf_o[1]`=1 if dropped. Then `ovf_clr_i` together with a new overflow leaves the flag at 1; `ovf_clr_i` alone clears it.
- **Grant and arrival in the same cycle.** Channel 0 receives a new sample in exactly the cycle it is granted. Required: no overflow, and both samples are eventually issued in order.
- **Enable.** With `chan_en_i[3]`=0, a channel 3 sample produces no issue and no result. A channel 3 sample pending when the enable drops is still issued.
- **Reset mid-stream.** Assert `rst` for 1 cycle with 2 results in flight. Required: no `valid_o` for those results; all outputs are 0 in the cycle after reset; the next sample behaves as in the single-sample scenario.

Source files
------------

// File: rtl/power_channel_arbiter.sv
// Round-robin sharing of one fixed-latency complex-to-power unit among NCH sample streams.
// Each returned power value is re-tagged with its channel by a delay line matched to PU_LAT.

module pca_lane #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld,
  input  logic          gnt,
  input  logic [DW-1:0] re,
  input  logic [DW-1:0] im,
  output logic          pend,
  output logic [DW-1:0] hold_re,
  output logic [DW-1:0] hold_im,
  output logic          ovf_set
);
  // A granted slot can accept a new sample in the same cycle it is drained.
  logic load;
  assign load    = vld & (~pend | gnt);
  assign ovf_set = vld & pend & ~gnt;

  always_ff @(posedge clk) begin
    if (rst)       pend <= 1'b0;
    else if (load) pend <= 1'b1;
    else if (gnt)  pend <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      hold_re <= re;
      hold_im <= im;
    end
  end
endmodule

module power_channel_arbiter #(
  parameter int DW     = 16,
  parameter int NCH    = 4,
  parameter int PU_LAT = 2,
  parameter int CW     = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] data_i_re,
  input  logic [NCH*DW-1:0] data_i_im,
  input  logic [NCH-1:0]    valid_i,
  input  logic [NCH-1:0]    chan_en_i,
  input  logic              ovf_clr_i,
  output logic [DW-1:0]     pu_re_o,
  output logic [DW-1:0]     pu_im_o,
  output logic              pu_valid_o,
  input  logic [DW:0]       pu_power_i,
  output logic [DW:0]       power_o,
  output logic [CW-1:0]     chan_o,
  output logic              valid_o,
  output logic [NCH-1:0]    ovf_o
);
  localparam int STAGES = PU_LAT - 1;

  logic [NCH-1:0]         pend, gnt, ovf_set;
  logic [NCH-1:0][DW-1:0] hold_re, hold_im;
  logic                   gnt_any;
  logic [CW-1:0]          gnt_idx, last, issue_ch;
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0][CW-1:0] ch_pipe;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    pca_lane #(.DW(DW)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .vld     (valid_i[k] & chan_en_i[k]),
      .gnt     (gnt[k]),
      .re      (data_i_re[k*DW +: DW]),
      .im      (data_i_im[k*DW +: DW]),
      .pend    (pend[k]),
      .hold_re (hold_re[k]),
      .hold_im (hold_im[k]),
      .ovf_set (ovf_set[k])
    );
  end

  // Search starts just after the last winner so every pending channel waits at most NCH-1 grants.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(last) + i) % NCH;
      if (!gnt_any && pend[CW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= CW'(NCH - 1);
      pu_valid_o <= 1'b0;
      pu_re_o    <= '0;
      pu_im_o    <= '0;
      issue_ch   <= '0;
    end else begin
      pu_valid_o <= gnt_any;
      if (gnt_any) begin
        last     <= gnt_idx;
        pu_re_o  <= hold_re[gnt_idx];
        pu_im_o  <= hold_im[gnt_idx];
        issue_ch <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      ch_pipe  <= '0;
      valid_o  <= 1'b0;
      power_o  <= '0;
      chan_o   <= '0;
    end else begin
      vld_pipe[0] <= pu_valid_o;
      ch_pipe[0]  <= issue_ch;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        ch_pipe[i]  <= ch_pipe[i-1];
      end
      valid_o <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        power_o <= pu_power_i;
        chan_o  <= ch_pipe[STAGES];
      end
    end
  end

  // A fresh overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) ovf_o <= '0;
    else     ovf_o <= (ovf_o & ~{NCH{ovf_clr_i}}) | ovf_set;
  end
endmodule

// File: tb/tb_power_channel_arbiter.sv
// Directed bench for power_channel_arbiter: per-channel result scoreboard plus issue-order queue,
// with a behavioural model of the shared power unit.

module tb_power_channel_arbiter;
  localparam int DW = 16, NCH = 4, PU_LAT = 2, CW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*DW-1:0] data_i_re = '0, data_i_im = '0;
  logic [NCH-1:0]    valid_i = '0, chan_en_i = '1;
  logic              ovf_clr_i = 1'b0;
  logic [DW-1:0]     pu_re_o, pu_im_o;
  logic              pu_valid_o;
  logic [DW:0]       pu_power_i;
  logic [DW:0]       power_o;
  logic [CW-1:0]     chan_o;
  logic              valid_o;
  logic [NCH-1:0]    ovf_o;

  power_channel_arbiter #(.DW(DW), .NCH(NCH), .PU_LAT(PU_LAT)) dut (
    .clk(clk), .rst(rst), .data_i_re(data_i_re), .data_i_im(data_i_im),
    .valid_i(valid_i), .chan_en_i(chan_en_i), .ovf_clr_i(ovf_clr_i),
    .pu_re_o(pu_re_o), .pu_im_o(pu_im_o), .pu_valid_o(pu_valid_o),
    .pu_power_i(pu_power_i), .power_o(power_o), .chan_o(chan_o),
    .valid_o(valid_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, iss_cnt = 0, res_cnt = 0;
  logic [DW:0]      sb_q [NCH][$];
  logic [2*DW-1:0]  iss_q[$];
  logic [DW:0]      pm [PU_LAT];

  function automatic logic [DW:0] pw(int re, int im);
    return (DW+1)'(re*re + im*im);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shared unit: fixed PU_LAT latency, garbage when nothing was issued.
  always @(posedge clk) begin
    pm[0] <= pu_valid_o ? pw($signed(pu_re_o), $signed(pu_im_o)) : (DW+1)'(17'h15A5A);
    for (int i = 1; i < PU_LAT; i++) pm[i] <= pm[i-1];
  end
  assign pu_power_i = pm[PU_LAT-1];

  always @(negedge clk) begin
    if (pu_valid_o) begin
      iss_cnt++;
      chk("iss_expected", 64'(iss_q.size() != 0), 1);
      if (iss_q.size() != 0) chk("iss_data", {pu_re_o, pu_im_o}, iss_q.pop_front());
    end
    if (valid_o) begin
      res_cnt++;
      chk("res_expected", 64'(sb_q[chan_o].size() != 0), 1);
      if (sb_q[chan_o].size() != 0) chk("res_power", power_o, sb_q[chan_o].pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    valid_i   = '0;
    ovf_clr_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic samp(int k, int re, int im, bit res, bit iss);
    data_i_re[k*DW +: DW] = DW'(re);
    data_i_im[k*DW +: DW] = DW'(im);
    valid_i[k] = 1'b1;
    if (res) sb_q[k].push_back(pw(re, im));
    if (iss) iss_q.push_back({DW'(re), DW'(im)});
  endtask

  task automatic single_sample(string pfx);
    samp(2, 3, -4, 1, 1); tick();
    chk({pfx, "_pu_valid_c1"}, pu_valid_o, 0); tick();
    chk({pfx, "_pu_valid_c2"}, pu_valid_o, 1);
    chk({pfx, "_pu_re_c2"}, pu_re_o, 3);
    chk({pfx, "_pu_im_c2"}, pu_im_o, 16'hFFFC);
    tick(); tick();
    chk({pfx, "_valid_c4"}, valid_o, 0); tick();
    chk({pfx, "_valid_c5"}, valid_o, 1);
    chk({pfx, "_power_c5"}, power_o, 25);
    chk({pfx, "_chan_c5"}, chan_o, 2);
    chk({pfx, "_ovf"}, ovf_o, 0);
    repeat (6) tick();
  endtask

  initial begin
    int r0, i0, left;
    do_reset();
    chk("rst_pu_valid", pu_valid_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_power", power_o, 0);
    chk("rst_chan", chan_o, 0);
    chk("rst_pu_re", {pu_re_o, pu_im_o}, 0);

    single_sample("ss");

    // Fairness: all channels every 4 cycles, 10 rounds.
    do_reset();
    r0 = res_cnt;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < NCH; k++) samp(k, k*16 + r, -(r+1), 1, 1);
      repeat (4) tick();
    end
    repeat (12) tick();
    chk("fair_results", res_cnt - r0, 40);
    chk("fair_ovf", ovf_o, 0);

    // Overflow on channel 1 while it waits behind channel 0.
    do_reset();
    for (int k = 0; k < NCH; k++) samp(k, k+1, k+1, 1, 1);
    tick();
    samp(1, 9, 9, 0, 0); tick();
    chk("ovf_set", ovf_o, 4'b0010);
    repeat (8) tick();
    chk("ovf_sticky", ovf_o, 4'b0010);
    ovf_clr_i = 1'b1; tick();
    chk("ovf_clr_alone", ovf_o, 0);
    for (int k = 0; k < NCH; k++) samp(k, k+5, 1, 1, 1);
    tick();
    samp(1, 9, 9, 0, 0); ovf_clr_i = 1'b1; tick();
    chk("ovf_clr_vs_new", ovf_o, 4'b0010);
    ovf_clr_i = 1'b1; tick();
    chk("ovf_clr_again", ovf_o, 0);
    repeat (8) tick();

    // New sample arrives in the cycle channel 0 is granted.
    do_reset();
    samp(0, 7, -1, 1, 1); tick();
    samp(0, 6, -2, 1, 1); tick();
    chk("gs_pu_re_first", pu_re_o, 7); tick();
    chk("gs_pu_valid_second", pu_valid_o, 1);
    chk("gs_pu_re_second", pu_re_o, 6);
    repeat (8) tick();
    chk("gs_ovf", ovf_o, 0);

    // Enable low blocks a sample; dropping it later keeps a pending one.
    do_reset();
    i0 = iss_cnt; r0 = res_cnt;
    chan_en_i[3] = 1'b0;
    samp(3, 5, 5, 0, 0); tick();
    repeat (8) tick();
    chk("en_off_iss", iss_cnt - i0, 0);
    chk("en_off_res", res_cnt - r0, 0);
    chan_en_i = '1;
    samp(0, 1, 2, 1, 1); samp(3, 2, 3, 1, 1); tick();
    chan_en_i[3] = 1'b0; tick();
    repeat (8) tick();
    chk("en_drop_iss", iss_cnt - i0, 2);
    chk("en_drop_res", res_cnt - r0, 2);
    chan_en_i = '1;

    // Reset with two results in flight.
    do_reset();
    r0 = res_cnt;
    samp(0, 3, 3, 0, 1); samp(1, 4, 4, 0, 1); tick();
    repeat (3) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("rs_pu_data", {pu_re_o, pu_im_o}, 0);
    chk("rs_pu_valid", pu_valid_o, 0);
    chk("rs_power", power_o, 0);
    chk("rs_chan", chan_o, 0);
    chk("rs_valid", valid_o, 0);
    chk("rs_ovf", ovf_o, 0);
    repeat (6) tick();
    chk("rs_no_result", res_cnt - r0, 0);
    single_sample("rs_ss");

    left = 0;
    for (int k = 0; k < NCH; k++) left += sb_q[k].size();
    chk("sb_drained", left, 0);
    chk("iss_drained", iss_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
